data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory responder for the MIPS pipeline: owns the 32-bit data RAM and services load/store requests issued by the memory stage. Word accesses complete in one cycle. Sub-word stores (SB/SH) are merged into the stored word by an internal read-modify-write sequence that stalls the pipeline for one cycle. Loads are lane-selected and sign- or zero-extended here, and a debug read port exposes RAM contents to the debug unit.

## Interface
- len, 32, data and address width
- RAM_DEPTH, 2048, number of 32-bit words
- NB_ADDR, $clog2(RAM_DEPTH), word-index width
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- in_req  in  1  access request valid this cycle
- in_we  in  1  1 = store, 0 = load
- in_addr  in  len  byte address; word index = in_addr[NB_ADDR+1:2], lane = in_addr[1:0]
- in_wdata  in  len  store data, right-aligned (byte in [7:0], half in [15:0])
- in_size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- in_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- out_rdata  out  len  extended load result, registered
- out_rvalid  out  1  one-cycle pulse, out_rdata valid
- out_stall  out  1  combinational; pipeline holds all in_* stable while high
- out_misaligned  out  1  one-cycle registered pulse on misaligned request
- debug_addr  in  NB_ADDR  word index for debug read
- debug_rdata  out  len  combinational RAM[debug_addr]

## Operation
- FSM states: IDLE and RMW_WR.
- Misaligned request: half with addr[0]=1, or word with addr[1:0]!=0.
  - No RAM write.
  - Next cycle: out_misaligned=1; for a load also out_rvalid=1 with out_rdata=0.
  - Stays in IDLE.
- Word store in IDLE: RAM[idx] <= in_wdata at the same edge; no stall.
- Load in IDLE: synchronous RAM read.
  - Next cycle: out_rvalid=1, out_rdata = selected lane extended to len.
  - Byte lane k uses bits [8k+7:8k]; half uses [15:0] if addr[1]=0, else [31:16] (little-endian).
  - No stall. Back-to-back loads are accepted every cycle.
- Sub-word store in IDLE:
  - out_stall=1 combinationally. RAM read issued. Request (idx, lane, size, wdata) captured. Go to RMW_WR.
- RMW_WR:
  - out_stall=0.
  - Merged word written: only the addressed byte or half is replaced, other lanes keep the read value.
  - The pipeline consumes the request at this edge; return to IDLE.
- in_req=0: no RAM access, outputs pulse-free.
- Debug port is independent of the FSM and reflects writes after the committing edge.

## Timing
- Reset values: out_rdata=0, out_rvalid=0, out_misaligned=0, FSM=IDLE, out_stall=0 (while reset high). RAM contents are not cleared.
- Reset asserted in RMW_WR: the write is aborted (RAM unchanged) and the FSM goes to IDLE.
- Load latency: 1 cycle. Word store: 0 stall cycles. Sub-word store: exactly 1 stall cycle, write committed at the end of the second cycle.
- Read-after-write: a load to the same word in the cycle after a store commits returns the new data.
- out_stall is a function of state and in_* only; no path from out_rdata.
- Request inputs are sampled in IDLE; in RMW_WR the captured copy is used, so in_* changes there are ignored.

## Test plan
- Word store 0xDEADBEEF @0x10, then load word @0x10 -> out_rvalid next cycle, out_rdata=0xDEADBEEF, out_stall never high.
- Word store 0x11223344 @0x20, SB 0xAA @0x21 -> out_stall high exactly 1 cycle; then load word @0x20 -> 0x1122AA44.
- Word store 0x8000F0FF @0x30:
  - LB @0x30 signed -> 0xFFFFFFFF; LBU @0x30 -> 0x000000FF.
  - LH @0x32 signed -> 0xFFFF8000; LHU @0x32 -> 0x00008000.
- SH @0x41 and LW @0x42 -> out_misaligned pulses one cycle each; LW returns out_rdata=0; RAM word 0x40 unchanged (check via debug_rdata).
- Reset asserted during RMW_WR of SB 0x55 @0x50 (word previously 0x0) -> debug_rdata[idx 0x14]=0, FSM IDLE, outputs 0.
- Alternating loads every cycle to 4 addresses -> one out_rvalid per cycle with the correct data each cycle.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-RAM responder for the MIPS memory stage.
// Word loads and stores complete in one cycle. SB/SH stores use a
// one-stall read-modify-write. Loads are lane-selected and extended here.
module data_mem_ctrl #(
  parameter int len       = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int NB_ADDR   = $clog2(RAM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_req,
  input  logic               in_we,
  input  logic [len-1:0]     in_addr,
  input  logic [len-1:0]     in_wdata,
  input  logic [1:0]         in_size,
  input  logic               in_unsigned,
  output logic [len-1:0]     out_rdata,
  output logic               out_rvalid,
  output logic               out_stall,
  output logic               out_misaligned,
  input  logic [NB_ADDR-1:0] debug_addr,
  output logic [len-1:0]     debug_rdata
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [len-1:0] ram [RAM_DEPTH];

  state_t             state;
  logic [NB_ADDR-1:0] rmw_idx;
  logic [1:0]         rmw_lane;
  logic               rmw_is_byte;
  logic [15:0]        rmw_wdata;
  logic [len-1:0]     rmw_word;

  // Request decode
  logic [NB_ADDR-1:0] idx;
  logic [1:0]         lane;
  logic               is_byte;
  logic               is_half;
  logic               is_word;
  logic               misaligned;
  logic               word_wr;
  logic               sub_wr;

  // Bits above the RAM's word index do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr[len-1:NB_ADDR+2];

  assign idx        = in_addr[NB_ADDR+1:2];
  assign lane       = in_addr[1:0];
  assign is_byte    = (in_size == SZ_BYTE);
  assign is_half    = (in_size == SZ_HALF);
  assign is_word    = !is_byte && !is_half;
  assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));

  assign word_wr = (state == IDLE) && !reset && in_req && in_we && is_word && !misaligned;
  assign sub_wr  = (state == IDLE) && !reset && in_req && in_we && !is_word && !misaligned;

  // Stall depends only on state and request inputs, never on read data.
  assign out_stall = sub_wr;

  assign debug_rdata = ram[debug_addr];

  // Select the addressed lane of a word and extend it to len bits.
  function automatic logic [len-1:0] load_extend(
    input logic [len-1:0] word,
    input logic [1:0]     ln,
    input logic           byte_sz,
    input logic           half_sz,
    input logic           uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {ln, 3'b000});
    h = ln[1] ? word[31:16] : word[15:0];
    if (byte_sz)      return {{(len-8){uns ? 1'b0 : b[7]}}, b};
    else if (half_sz) return {{(len-16){uns ? 1'b0 : h[15]}}, h};
    else              return word;
  endfunction

  // Replace only the addressed byte or half of the old word.
  function automatic logic [len-1:0] merge_lane(
    input logic [len-1:0] old,
    input logic [15:0]    wdata,
    input logic [1:0]     ln,
    input logic           byte_sz
  );
    logic [len-1:0] mask;
    logic [len-1:0] data;
    if (byte_sz) begin
      mask = {{(len-8){1'b0}}, 8'hFF} << {ln, 3'b000};
      data = {{(len-8){1'b0}}, wdata[7:0]} << {ln, 3'b000};
    end else begin
      mask = {{(len-16){1'b0}}, 16'hFFFF} << {ln[1], 4'b0000};
      data = {{(len-16){1'b0}}, wdata} << {ln[1], 4'b0000};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  // RAM write port: word stores in IDLE, merged word in RMW_WR (aborted by reset).
  logic               ram_we;
  logic [NB_ADDR-1:0] ram_waddr;
  logic [len-1:0]     ram_wdata;

  assign ram_we    = word_wr || ((state == RMW_WR) && !reset);
  assign ram_waddr = (state == RMW_WR) ? rmw_idx : idx;
  assign ram_wdata = (state == RMW_WR)
                     ? merge_lane(rmw_word, rmw_wdata, rmw_lane, rmw_is_byte)
                     : in_wdata;

  // RAM storage update.
  // NOTE: the RAM array has no reset branch so it maps onto block RAM; its
  // contents survive reset, and only the control state below is cleared.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Control FSM with registered load/misalignment outputs and RMW capture.
  // NOTE: every assignment here is non-blocking so all registers see the
  // pre-edge values of each other, matching real flip-flop behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      out_rdata      <= '0;
      out_rvalid     <= 1'b0;
      out_misaligned <= 1'b0;
      rmw_idx        <= '0;
      rmw_lane       <= '0;
      rmw_is_byte    <= 1'b0;
      rmw_wdata      <= '0;
      rmw_word       <= '0;
    end else begin
      out_rvalid     <= 1'b0;
      out_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (in_req) begin
            if (misaligned) begin
              out_misaligned <= 1'b1;
              if (!in_we) begin
                out_rvalid <= 1'b1;
                out_rdata  <= '0;
              end
            end else if (!in_we) begin
              out_rvalid <= 1'b1;
              out_rdata  <= load_extend(ram[idx], lane, is_byte, is_half, in_unsigned);
            end else if (!is_word) begin
              rmw_idx     <= idx;
              rmw_lane    <= lane;
              rmw_is_byte <= is_byte;
              rmw_wdata   <= in_wdata[15:0];
              rmw_word    <= ram[idx];
              state       <= RMW_WR;
            end
          end
        end
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. A byte-addressed little-endian
// memory model predicts every output; a compare process checks each cycle.
module tb_data_mem_ctrl;

  localparam int LEN     = 32;
  localparam int NB_ADDR = 11;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_req;
  logic               in_we;
  logic [LEN-1:0]     in_addr;
  logic [LEN-1:0]     in_wdata;
  logic [1:0]         in_size;
  logic               in_unsigned;
  logic [LEN-1:0]     out_rdata;
  logic               out_rvalid;
  logic               out_stall;
  logic               out_misaligned;
  logic [NB_ADDR-1:0] debug_addr;
  logic [LEN-1:0]     debug_rdata;

  data_mem_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .in_req         (in_req),
    .in_we          (in_we),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_size        (in_size),
    .in_unsigned    (in_unsigned),
    .out_rdata      (out_rdata),
    .out_rvalid     (out_rvalid),
    .out_stall      (out_stall),
    .out_misaligned (out_misaligned),
    .debug_addr     (debug_addr),
    .debug_rdata    (debug_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rvalid;
    logic        mis;
    logic [31:0] rdata;
  } exp_t;

  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10, W3 = 2'b11;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_cnt = 0;
  int   rvalid_cnt = 0;
  bit   chk_en = 1'b0;
  exp_t exp_cur = '{rvalid: 1'b0, mis: 1'b0, rdata: 32'h0};
  exp_t exp_nxt = '{rvalid: 1'b0, mis: 1'b0, rdata: 32'h0};
  logic exp_stall = 1'b0;

  // Byte-addressed reference memory.
  logic [7:0] mem_b [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit uns);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | ({24'h0, mem_b[int'(addr) + i]} << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] data);
    for (int i = 0; i < n; i++) mem_b[int'(addr) + i] = 8'(data >> (8 * i));
  endtask

  function automatic logic [31:0] model_word(input int widx);
    return model_load(32'(widx * 4), 4, 1'b1);
  endfunction

  // Advance one clock: expectations for this new cycle become current.
  task automatic tick();
    @(posedge clk);
    exp_cur = exp_nxt;
    exp_nxt = '{rvalid: 1'b0, mis: 1'b0, rdata: 32'h0};
    #1;
  endtask

  task automatic idle(input int n);
    in_req    = 1'b0;
    exp_stall = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issue one request, holding it through any stall, and predict its outputs.
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns);
    int nbytes;
    bit mis;
    nbytes = (size == H) ? 2 : (size == B) ? 1 : 4;
    mis    = (int'(addr) % nbytes) != 0;
    in_req = 1'b1; in_we = we; in_addr = addr; in_wdata = wdata;
    in_size = size; in_unsigned = uns;
    exp_stall = we && !mis && (nbytes < 4);
    if (mis) begin
      exp_nxt.mis = 1'b1;
      if (!we) begin
        exp_nxt.rvalid = 1'b1;
        exp_nxt.rdata  = 32'h0;
      end
    end else if (!we) begin
      exp_nxt.rvalid = 1'b1;
      exp_nxt.rdata  = model_load(addr, nbytes, uns);
    end else begin
      model_store(addr, nbytes, wdata);
    end
    tick();
    if (exp_stall) begin
      exp_stall = 1'b0;
      tick();
    end
    in_req    = 1'b0;
    exp_stall = 1'b0;
  endtask

  // Compare process: check every output against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'h0, out_stall}, {31'h0, exp_stall});
      check("rvalid", {31'h0, out_rvalid}, {31'h0, exp_cur.rvalid});
      check("misaligned", {31'h0, out_misaligned}, {31'h0, exp_cur.mis});
      if (exp_cur.rvalid) check("rdata", out_rdata, exp_cur.rdata);
      if (out_stall) stall_cnt++;
      if (out_rvalid) rvalid_cnt++;
    end
  end

  int s0;
  int r0;
  logic [31:0] lp_addr [4] = '{32'h60, 32'h64, 32'h68, 32'h6C};
  logic [31:0] lp_data [4] = '{32'h0102_0304, 32'hA5A5_5A5A, 32'hFFFF_0000, 32'h7654_3210};

  initial begin
    reset = 1'b1; in_req = 1'b0; in_we = 1'b0; in_addr = '0; in_wdata = '0;
    in_size = W; in_unsigned = 1'b0; debug_addr = '0;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    check("reset_rdata", out_rdata, 32'h0);
    check("reset_rvalid", {31'h0, out_rvalid}, 32'h0);
    check("reset_mis", {31'h0, out_misaligned}, 32'h0);
    check("reset_stall", {31'h0, out_stall}, 32'h0);
    reset = 1'b0;
    idle(1);

    // Word store then word load.
    req(1'b1, 32'h10, 32'hDEAD_BEEF, W, 1'b0);
    req(1'b0, 32'h10, 32'h0, W, 1'b0);
    check("lit_lw_10", out_rdata, 32'hDEAD_BEEF);
    req(1'b0, 32'h10, 32'h0, W3, 1'b0);
    check("lit_lw_size3", out_rdata, 32'hDEAD_BEEF);

    // Byte store merged by read-modify-write.
    req(1'b1, 32'h20, 32'h1122_3344, W, 1'b0);
    s0 = stall_cnt;
    req(1'b1, 32'h21, 32'h0000_00AA, B, 1'b0);
    check("sb_stall_cycles", 32'(stall_cnt - s0), 32'd1);
    req(1'b0, 32'h20, 32'h0, W, 1'b0);
    check("lit_sb_merge", out_rdata, 32'h1122_AA44);
    debug_addr = 11'h8; #1;
    check("debug_w20", debug_rdata, model_word(8));

    // Lane selection and extension.
    req(1'b1, 32'h30, 32'h8000_F0FF, W, 1'b0);
    req(1'b0, 32'h30, 32'h0, B, 1'b0);
    check("lit_lb", out_rdata, 32'hFFFF_FFFF);
    req(1'b0, 32'h30, 32'h0, B, 1'b1);
    check("lit_lbu", out_rdata, 32'h0000_00FF);
    req(1'b0, 32'h32, 32'h0, H, 1'b0);
    check("lit_lh", out_rdata, 32'hFFFF_8000);
    req(1'b0, 32'h32, 32'h0, H, 1'b1);
    check("lit_lhu", out_rdata, 32'h0000_8000);
    req(1'b0, 32'h33, 32'h0, B, 1'b0);
    check("lit_lb3", out_rdata, 32'hFFFF_FF80);
    req(1'b1, 32'h32, 32'h0000_1234, H, 1'b0);
    req(1'b0, 32'h30, 32'h0, W, 1'b0);
    check("lit_sh_merge", out_rdata, 32'h1234_F0FF);

    // Misaligned accesses leave RAM untouched.
    req(1'b1, 32'h40, 32'hCAFE_F00D, W, 1'b0);
    req(1'b1, 32'h41, 32'h0000_BBBB, H, 1'b0);
    check("lit_sh_mis", {31'h0, out_misaligned}, 32'h1);
    req(1'b0, 32'h42, 32'h0, W, 1'b0);
    check("lit_lw_mis", {31'h0, out_misaligned}, 32'h1);
    check("lit_lw_mis_rdata", out_rdata, 32'h0);
    idle(1);
    debug_addr = 11'h10; #1;
    check("lit_debug_w40", debug_rdata, 32'hCAFE_F00D);
    req(1'b0, 32'h40, 32'h0, W, 1'b0);
    check("lit_lw_40", out_rdata, 32'hCAFE_F00D);

    // Reset during RMW_WR aborts the merge.
    req(1'b1, 32'h50, 32'h0, W, 1'b0);
    in_req = 1'b1; in_we = 1'b1; in_addr = 32'h50; in_wdata = 32'h55;
    in_size = B; in_unsigned = 1'b0;
    exp_stall = 1'b1;
    tick();
    reset = 1'b1;
    exp_stall = 1'b0;
    tick();
    in_req = 1'b0;
    tick();
    check("rst_rdata", out_rdata, 32'h0);
    check("rst_rvalid", {31'h0, out_rvalid}, 32'h0);
    reset = 1'b0;
    debug_addr = 11'h14; #1;
    check("lit_rst_abort", debug_rdata, 32'h0);
    req(1'b0, 32'h50, 32'h0, W, 1'b0);
    check("rst_fsm_idle", {31'h0, out_rvalid}, 32'h1);

    // Back-to-back loads across four words.
    for (int i = 0; i < 4; i++) req(1'b1, lp_addr[i], lp_data[i], W, 1'b0);
    r0 = rvalid_cnt;
    for (int i = 0; i < 8; i++) req(1'b0, lp_addr[i % 4], 32'h0, W, 1'b0);
    idle(1);
    check("b2b_rvalid_count", 32'(rvalid_cnt - r0), 32'd8);
    for (int i = 0; i < 4; i++) req(1'b0, lp_addr[i] + 32'(i), 32'h0, B, i[0]);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
